mmio_uart_bus_master: RTL and testbench

//  Bus initiator for the FPro MMIO bus: turns a byte-stream command protocol into single-cycle

---
 rtl/mmio_uart_bus_master.sv | 250 +++++++++++++++++++++++++
 tb/tb_mmio_uart_bus_master.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_bus_master.sv
// mmio_uart_bus_master
//   Bridges a byte-stream command protocol, carried over a valid/ready UART
//   byte pair, onto the FPro MMIO bus. A host can then peek and poke slot
//   registers without running code on the processor.
//
//   Frames (multi-byte fields are sent MSB first):
//     write: 'W'(0x57) A2 A1 A0 D3 D2 D1 D0  -> reply 'K'(0x4B)
//     read : 'R'(0x52) A2 A1 A0              -> reply D3 D2 D1 D0
//     any other leading byte                 -> reply '?'(0x3F)
//
//   Ports
//     clk, reset                 system clock, synchronous active-high reset
//     rx_data/rx_valid/rx_ready  incoming command bytes
//     tx_data/tx_valid/tx_ready  outgoing response bytes
//     mmio_cs/read/write         one-cycle bus strobes
//     mmio_addr, mmio_wr_data    bus address / write data
//     mmio_rd_data               bus read data, sampled at the end of the read strobe
//     busy                       high whenever a frame or response is in flight
//
//   All control outputs are registered. They are decoded from the next state,
//   so each one lines up with the state it belongs to.
module mmio_uart_bus_master #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        mmio_cs,
    output logic        mmio_read,
    output logic        mmio_write,
    output logic [20:0] mmio_addr,
    output logic [31:0] mmio_wr_data,
    input  logic [31:0] mmio_rd_data,
    output logic        busy
);

    localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]  TMO_ONE  = TW'(1);
    localparam logic [7:0]     CMD_WR   = 8'h57;
    localparam logic [7:0]     CMD_RD   = 8'h52;
    localparam logic [7:0]     RSP_OK   = 8'h4B;
    localparam logic [7:0]     RSP_ERR  = 8'h3F;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_DATA   = 3'd2,
        S_BUS_WR = 3'd3,
        S_BUS_RD = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    state_t        state_r;
    state_t        next_state_s;
    logic          op_wr_r;
    logic [2:0]    byte_cnt_r;
    logic [20:0]   addr_r;       // only the low 21 address bits survive the shift
    logic [31:0]   data_r;
    logic [31:0]   resp_r;       // response bytes, next byte to send in [31:24]
    logic [2:0]    resp_left_r;
    logic [TW-1:0] tmo_r;

    logic rx_ready_r, tx_valid_r, cs_r, rd_r, wr_r, busy_r;
    logic rx_ready_s, tx_valid_s, cs_s, rd_s, wr_s, busy_s;
    logic rx_fire_s, tx_fire_s;

    assign rx_fire_s = rx_valid & rx_ready_r;
    assign tx_fire_s = tx_valid_r & tx_ready;

    // State register and registered control outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_IDLE;
            rx_ready_r <= 1'b0;
            tx_valid_r <= 1'b0;
            cs_r       <= 1'b0;
            rd_r       <= 1'b0;
            wr_r       <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            rx_ready_r <= rx_ready_s;
            tx_valid_r <= tx_valid_s;
            cs_r       <= cs_s;
            rd_r       <= rd_s;
            wr_r       <= wr_s;
            busy_r     <= busy_s;
        end
    end

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (rx_fire_s) begin
                    if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                        next_state_s = S_ADDR;
                    end else begin
                        next_state_s = S_RESP;
                    end
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_ADDR: begin
                if (rx_fire_s) begin
                    if (byte_cnt_r == 3'd2) begin
                        next_state_s = op_wr_r ? S_DATA : S_BUS_RD;
                    end else begin
                        next_state_s = S_ADDR;
                    end
                end else if (tmo_r == TMO_LAST) begin
                    next_state_s = S_IDLE;      // silent abort of a stalled frame
                end else begin
                    next_state_s = S_ADDR;
                end
            end
            S_DATA: begin
                if (rx_fire_s) begin
                    if (byte_cnt_r == 3'd3) begin
                        next_state_s = S_BUS_WR;
                    end else begin
                        next_state_s = S_DATA;
                    end
                end else if (tmo_r == TMO_LAST) begin
                    next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_DATA;
                end
            end
            S_BUS_WR: next_state_s = S_RESP;
            S_BUS_RD: next_state_s = S_RESP;
            S_RESP: begin
                if (tx_fire_s && resp_left_r == 3'd1) begin
                    next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_RESP;
                end
            end
            default: next_state_s = S_IDLE;
        endcase
    end

    // Control outputs for the state being entered
    always_comb begin
        rx_ready_s = 1'b0;
        tx_valid_s = 1'b0;
        cs_s       = 1'b0;
        rd_s       = 1'b0;
        wr_s       = 1'b0;
        busy_s     = 1'b1;
        case (next_state_s)
            S_IDLE: begin
                rx_ready_s = 1'b1;
                busy_s     = 1'b0;
            end
            S_ADDR, S_DATA: rx_ready_s = 1'b1;
            S_BUS_WR: begin
                cs_s = 1'b1;
                wr_s = 1'b1;
            end
            S_BUS_RD: begin
                cs_s = 1'b1;
                rd_s = 1'b1;
            end
            S_RESP: tx_valid_s = 1'b1;
            default: busy_s = 1'b0;
        endcase
    end

    // Frame assembly, timeout counting and response shifting
    always_ff @(posedge clk) begin
        if (reset) begin
            op_wr_r     <= 1'b0;
            byte_cnt_r  <= 3'd0;
            addr_r      <= 21'd0;
            data_r      <= 32'd0;
            resp_r      <= 32'd0;
            resp_left_r <= 3'd0;
            tmo_r       <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (rx_fire_s) begin
                        op_wr_r    <= (rx_data == CMD_WR);
                        byte_cnt_r <= 3'd0;
                        tmo_r      <= '0;
                        if (rx_data != CMD_WR && rx_data != CMD_RD) begin
                            resp_r      <= {RSP_ERR, 24'h000000};
                            resp_left_r <= 3'd1;
                        end
                    end
                end
                S_ADDR: begin
                    if (rx_fire_s) begin
                        addr_r     <= {addr_r[12:0], rx_data};
                        byte_cnt_r <= (byte_cnt_r == 3'd2) ? 3'd0 : byte_cnt_r + 3'd1;
                        tmo_r      <= '0;
                    end else begin
                        tmo_r <= tmo_r + TMO_ONE;
                    end
                end
                S_DATA: begin
                    if (rx_fire_s) begin
                        data_r     <= {data_r[23:0], rx_data};
                        byte_cnt_r <= byte_cnt_r + 3'd1;
                        tmo_r      <= '0;
                    end else begin
                        tmo_r <= tmo_r + TMO_ONE;
                    end
                end
                S_BUS_WR: begin
                    resp_r      <= {RSP_OK, 24'h000000};
                    resp_left_r <= 3'd1;
                end
                S_BUS_RD: begin
                    resp_r      <= mmio_rd_data;   // captured at the end of the strobe cycle
                    resp_left_r <= 3'd4;
                end
                S_RESP: begin
                    if (tx_fire_s) begin
                        resp_r      <= {resp_r[23:0], 8'h00};
                        resp_left_r <= resp_left_r - 3'd1;
                    end
                end
                default: begin
                    tmo_r <= '0;
                end
            endcase
        end
    end

    assign rx_ready     = rx_ready_r;
    assign tx_valid     = tx_valid_r;
    assign tx_data      = resp_r[31:24];
    assign mmio_cs      = cs_r;
    assign mmio_read    = rd_r;
    assign mmio_write   = wr_r;
    assign mmio_addr    = addr_r;
    assign mmio_wr_data = data_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_mmio_uart_bus_master.sv
// Testbench for mmio_uart_bus_master.
// A frame/response-queue model predicts every output on every cycle, and
// directed scenarios pin the model with literal expectations.
module tb_mmio_uart_bus_master;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        mmio_cs, mmio_read, mmio_write;
    logic [20:0] mmio_addr;
    logic [31:0] mmio_wr_data;
    logic [31:0] mmio_rd_data;
    logic        busy;
    logic [31:0] rd_val = 32'hDEADBEEF;

    // Bus slave: real data only while the read strobe is up, junk otherwise
    assign mmio_rd_data = mmio_read ? rd_val : ~rd_val;

    mmio_uart_bus_master #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .mmio_cs(mmio_cs), .mmio_read(mmio_read), .mmio_write(mmio_write),
        .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data),
        .mmio_rd_data(mmio_rd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    bit          started = 1'b0;
    bit          zero = 1'b0;        // reset sampled at the last edge: all outputs 0
    logic [7:0]  frame[$];           // bytes of the frame being received
    logic [7:0]  resp_q[$];          // bytes still to be sent
    int          strobe = 0;         // 0 none, 1 write, 2 read this cycle
    int          idle = 0;
    logic [20:0] exp_addr = 21'd0;
    logic [31:0] exp_wd = 32'd0;

    function automatic bit m_rx_ready();
        return !zero && strobe == 0 && resp_q.size() == 0;
    endfunction

    function automatic bit m_busy();
        return !zero && (frame.size() > 0 || strobe != 0 || resp_q.size() > 0);
    endfunction

    always @(posedge clk) begin
        bit          rx_fire;
        bit          tx_fire;
        logic [23:0] a24;
        if (reset) begin
            started = 1'b1;
            zero = 1'b1;
            frame.delete();
            resp_q.delete();
            strobe = 0;
            idle = 0;
        end else if (started) begin
            rx_fire = rx_valid && m_rx_ready();
            tx_fire = !zero && resp_q.size() > 0 && tx_ready;
            zero = 1'b0;
            if (tx_fire) void'(resp_q.pop_front());
            if (strobe == 1) begin
                resp_q.push_back(8'h4B);
            end else if (strobe == 2) begin
                resp_q.push_back(rd_val[31:24]);
                resp_q.push_back(rd_val[23:16]);
                resp_q.push_back(rd_val[15:8]);
                resp_q.push_back(rd_val[7:0]);
            end
            strobe = 0;
            if (rx_fire) begin
                idle = 0;
                if (frame.size() == 0 && rx_data != 8'h57 && rx_data != 8'h52) begin
                    resp_q.push_back(8'h3F);
                end else begin
                    frame.push_back(rx_data);
                    if ((frame[0] == 8'h57 && frame.size() == 8) ||
                        (frame[0] == 8'h52 && frame.size() == 4)) begin
                        a24 = {frame[1], frame[2], frame[3]};
                        exp_addr = a24[20:0];
                        if (frame[0] == 8'h57) begin
                            exp_wd = {frame[4], frame[5], frame[6], frame[7]};
                            strobe = 1;
                        end else begin
                            strobe = 2;
                        end
                        frame.delete();
                    end
                end
            end else if (frame.size() > 0) begin
                idle++;
                if (idle == T) begin
                    frame.delete();
                    idle = 0;
                end
            end
        end
    end

    // ---------------- compare + logging ----------------
    logic [7:0]  tx_log[$];
    logic [20:0] s_addr_q[$];
    logic [31:0] s_wd_q[$];
    logic [1:0]  s_op_q[$];          // {read, write}

    always @(negedge clk) begin
        if (started) begin
            chk("rx_ready", rx_ready, m_rx_ready());
            chk("tx_valid", tx_valid, !zero && resp_q.size() > 0);
            chk("busy", busy, m_busy());
            chk("mmio_cs", mmio_cs, strobe != 0);
            chk("mmio_write", mmio_write, strobe == 1);
            chk("mmio_read", mmio_read, strobe == 2);
            chk("rd_wr_excl", mmio_read & mmio_write, 1'b0);
            if (!zero && resp_q.size() > 0) chk("tx_data", tx_data, resp_q[0]);
            if (strobe != 0) chk("mmio_addr", mmio_addr, exp_addr);
            if (strobe == 1) chk("mmio_wr_data", mmio_wr_data, exp_wd);
            if (zero) begin
                chk("rst_tx_data", tx_data, 8'h00);
                chk("rst_addr", mmio_addr, 21'd0);
                chk("rst_wr_data", mmio_wr_data, 32'd0);
            end
            if (tx_valid && tx_ready) tx_log.push_back(tx_data);
            if (mmio_cs) begin
                s_addr_q.push_back(mmio_addr);
                s_wd_q.push_back(mmio_wr_data);
                s_op_q.push_back({mmio_read, mmio_write});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        int w;
        rx_data = b;
        rx_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!rx_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!rx_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL rx_accept_timeout: byte 0x%0h never accepted", b);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i]);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        @(negedge clk);
        while ((busy || !rx_ready) && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (busy || !rx_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL idle_timeout: busy=%0b rx_ready=%0b", busy, rx_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        tx_log.delete();
        s_addr_q.delete();
        s_wd_q.delete();
        s_op_q.delete();
    endtask

    task automatic chk_read_resp(input string tag, input logic [31:0] v);
        chk({tag, "_ntx"}, tx_log.size(), 4);
        chk({tag, "_tx0"}, tx_log[0], v[31:24]);
        chk({tag, "_tx1"}, tx_log[1], v[23:16]);
        chk({tag, "_tx2"}, tx_log[2], v[15:8]);
        chk({tag, "_tx3"}, tx_log[3], v[7:0]);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("lit_reset_busy", busy, 1'b0);
        chk("lit_reset_rx_ready", rx_ready, 1'b0);
        reset = 1'b0;
        wait_idle();

        // Write 0x12345678 to 0x0000A0
        clear_logs();
        send_frame('{8'h57, 8'h00, 8'h00, 8'hA0, 8'h12, 8'h34, 8'h56, 8'h78});
        wait_idle();
        chk("lit_wr_nstrobe", s_op_q.size(), 1);
        chk("lit_wr_op", s_op_q[0], 2'b01);
        chk("lit_wr_addr", s_addr_q[0], 21'h0000A0);
        chk("lit_wr_data", s_wd_q[0], 32'h12345678);
        chk("lit_wr_ntx", tx_log.size(), 1);
        chk("lit_wr_tx", tx_log[0], 8'h4B);

        // Read 0x000021 returning 0xDEADBEEF
        clear_logs();
        rd_val = 32'hDEADBEEF;
        send_frame('{8'h52, 8'h00, 8'h00, 8'h21});
        wait_idle();
        chk("lit_rd_nstrobe", s_op_q.size(), 1);
        chk("lit_rd_op", s_op_q[0], 2'b10);
        chk("lit_rd_addr", s_addr_q[0], 21'h000021);
        chk_read_resp("lit_rd", 32'hDEADBEEF);

        // Unknown command byte
        clear_logs();
        send_byte(8'h41);
        wait_idle();
        chk("lit_unk_nstrobe", s_op_q.size(), 0);
        chk("lit_unk_ntx", tx_log.size(), 1);
        chk("lit_unk_tx", tx_log[0], 8'h3F);

        // Upper address bits ignored
        clear_logs();
        rd_val = 32'h01020304;
        send_frame('{8'h52, 8'hFF, 8'hFF, 8'hFF});
        wait_idle();
        chk("lit_hi_addr", s_addr_q[0], 21'h1FFFFF);
        chk_read_resp("lit_hi", 32'h01020304);

        // Timeout mid-frame, then a normal read
        clear_logs();
        send_frame('{8'h57, 8'h00});
        repeat (T + 4) @(posedge clk);
        #1;
        chk("lit_tmo_busy", busy, 1'b0);
        chk("lit_tmo_nstrobe", s_op_q.size(), 0);
        chk("lit_tmo_ntx", tx_log.size(), 0);
        rd_val = 32'hDEADBEEF;
        send_frame('{8'h52, 8'h00, 8'h00, 8'hA0});
        wait_idle();
        chk("lit_tmo_rd_op", s_op_q[0], 2'b10);
        chk("lit_tmo_rd_addr", s_addr_q[0], 21'h0000A0);
        chk_read_resp("lit_tmo", 32'hDEADBEEF);

        // Backpressure on the read response
        clear_logs();
        tx_ready = 1'b0;
        send_frame('{8'h52, 8'h00, 8'h00, 8'hA0});
        repeat (10) @(posedge clk);
        #1;
        chk("lit_bp_tx_data", tx_data, 8'hDE);
        chk("lit_bp_tx_valid", tx_valid, 1'b1);
        chk("lit_bp_rx_ready", rx_ready, 1'b0);
        tx_ready = 1'b1;
        wait_idle();
        chk_read_resp("lit_bp", 32'hDEADBEEF);

        // Reset in the middle of a write frame
        clear_logs();
        send_frame('{8'h57, 8'h00, 8'h00, 8'hA0, 8'h12});
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("lit_mrst_busy", busy, 1'b0);
        chk("lit_mrst_rx_ready", rx_ready, 1'b0);
        @(posedge clk);
        #1;
        send_frame('{8'h52, 8'h00, 8'h00, 8'hA0});
        wait_idle();
        chk("lit_mrst_nstrobe", s_op_q.size(), 1);
        chk("lit_mrst_op", s_op_q[0], 2'b10);
        chk_read_resp("lit_mrst", 32'hDEADBEEF);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
